dispense_sequencer: RTL and testbench

Central controller for the candy dispenser. It takes the Raspberry Pi command pins (3-bit motor test state, 2-bit amount, candyflag) and a slow heartbeat tick. It sequences the stepper and DC motor through jog, dispense and drain phases, then returns a handshake to the Pi. Its outputs are registered enables, directions and speed selects; the existing clock-division and PWM blocks consume them to gate step and PWM waveforms onto the GPIO pins.

---
 rtl/dispense_sequencer_pkg.sv | 90 +++++++++
 rtl/dispense_sequencer_sync.sv | 45 ++++
 rtl/dispense_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_dispense_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dispense_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispense_sequencer_pkg
// Description : Shared types and encodings for the candy dispenser sequencer:
//               FSM state enum, DC speed/direction codes, amount codes and
//               the jog-mode motor decode.
// Revision    : 1.0 - initial release
// ============================================================================
package dispense_sequencer_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // DC motor PWM speed selects
    localparam logic [1:0] SPD_OFF  = 2'b00;
    localparam logic [1:0] SPD_SLOW = 2'b01;
    localparam logic [1:0] SPD_MED  = 2'b10;
    localparam logic [1:0] SPD_FAST = 2'b11;

    // Dispense amount codes from the Pi
    localparam logic [1:0] AMT_SMALL   = 2'b00;
    localparam logic [1:0] AMT_MED     = 2'b01;
    localparam logic [1:0] AMT_LARGE   = 2'b10;
    localparam logic [1:0] AMT_INVALID = 2'b11;

    // DC H-bridge direction: bit 0 drives IN-A, bit 1 drives IN-B
    localparam logic [1:0] DC_FWD = 2'b10;
    localparam logic [1:0] DC_REV = 2'b01;

    // Jog-mode motor test codes
    localparam logic [2:0] JOG_STEP_FWD    = 3'b001;
    localparam logic [2:0] JOG_STEP_REV    = 3'b010;
    localparam logic [2:0] JOG_STEP_FWD_B  = 3'b011;
    localparam logic [2:0] JOG_DC_FWD_SLOW = 3'b100;
    localparam logic [2:0] JOG_DC_REV_SLOW = 3'b101;
    localparam logic [2:0] JOG_DC_FWD_FAST = 3'b110;

    // Bundle of all motor-facing outputs
    typedef struct packed {
        logic       stepper_en;
        logic       stepper_dir;
        logic [1:0] dc_dir;
        logic [1:0] dc_speed;
    } motor_t;

    localparam motor_t MOTORS_OFF = '{stepper_en: 1'b0, stepper_dir: 1'b0,
                                      dc_dir: DC_FWD, dc_speed: SPD_OFF};

    localparam motor_t MOTORS_RUN = '{stepper_en: 1'b1, stepper_dir: 1'b0,
                                      dc_dir: DC_REV, dc_speed: SPD_MED};

    // Map a jog command onto the motor outputs; unknown codes stop everything
    function automatic motor_t jog_decode(input logic [2:0] cmd);
        motor_t m;
        m = MOTORS_OFF;
        case (cmd)
            JOG_STEP_FWD, JOG_STEP_FWD_B: begin
                m.stepper_en  = 1'b1;
                m.stepper_dir = 1'b0;
            end
            JOG_STEP_REV: begin
                m.stepper_en  = 1'b1;
                m.stepper_dir = 1'b1;
            end
            JOG_DC_FWD_SLOW: begin
                m.dc_dir   = DC_FWD;
                m.dc_speed = SPD_SLOW;
            end
            JOG_DC_REV_SLOW: begin
                m.dc_dir   = DC_REV;
                m.dc_speed = SPD_SLOW;
            end
            JOG_DC_FWD_FAST: begin
                m.dc_dir   = DC_FWD;
                m.dc_speed = SPD_FAST;
            end
            default: m = MOTORS_OFF;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispense_sequencer_sync.sv
`default_nettype none
// ============================================================================
// Module      : pi_input_sync
// Description : Multi-stage synchronizer for a bus of asynchronous Pi pins,
//               with a rising-edge detect on one selected bit.
// Revision    : 1.0 - initial release
// ============================================================================
module pi_input_sync #(
    parameter int               WIDTH    = 6,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               EDGE_BIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             rise_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic             edge_prev_q;

    // Shift the pins through the flop chain; the edge history starts at the
    // reset value so that a level already present at reset exit is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
            edge_prev_q <= RST_VAL[EDGE_BIT];
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            edge_prev_q <= stage_q[STAGES-1][EDGE_BIT];
        end
    end

    assign sync_o = stage_q[STAGES-1];
    assign rise_o = stage_q[STAGES-1][EDGE_BIT] & ~edge_prev_q;

endmodule
`default_nettype wire

// File: rtl/dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dispense_sequencer
// Description : Candy dispenser controller. Synchronizes the Pi command pins,
//               runs jog mode in IDLE and sequences LOAD/RUN/DRAIN/DONE for a
//               dispense, producing registered motor enables and speed codes.
// Revision    : 1.0 - initial release
// ============================================================================
module dispense_sequencer
    import dispense_sequencer_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SMALL_TICKS = 20,
    parameter int MED_TICKS   = 35,
    parameter int LARGE_TICKS = 45,
    parameter int DRAIN_TICKS = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [2:0]       cmd_state,
    input  logic [1:0]       cmd_amount,
    input  logic             candyflag,
    output logic             stepper_en,
    output logic             stepper_dir,
    output logic [1:0]       dc_dir,
    output logic [1:0]       dc_speed,
    output logic             handshake,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] c_small_ticks = CNT_W'(SMALL_TICKS);
    localparam logic [CNT_W-1:0] c_med_ticks   = CNT_W'(MED_TICKS);
    localparam logic [CNT_W-1:0] c_large_ticks = CNT_W'(LARGE_TICKS);
    localparam logic [CNT_W-1:0] c_drain_ticks = CNT_W'(DRAIN_TICKS);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    // Synchronizer bus layout: {amount[1:0], state[2:0], candyflag}.
    // candyflag resets high so a flag held across reset exit never looks
    // like a fresh request.
    localparam logic [5:0] c_sync_rst = 6'b00_000_1;

    logic [5:0] sync_bus_w;
    logic       cf_rise_w;
    logic       cf_w;
    logic [2:0] cmd_state_w;
    logic [1:0] cmd_amount_w;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] drain_q,     drain_d;
    motor_t           motor_q,     motor_d;
    logic             handshake_q, handshake_d;
    logic             busy_q,      busy_d;
    logic             err_q,       err_d;

    pi_input_sync #(
        .WIDTH    (6),
        .STAGES   (SYNC_STAGES),
        .RST_VAL  (c_sync_rst),
        .EDGE_BIT (0)
    ) u_pi_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i ({cmd_amount, cmd_state, candyflag}),
        .sync_o  (sync_bus_w),
        .rise_o  (cf_rise_w)
    );

    assign cf_w         = sync_bus_w[0];
    assign cmd_state_w  = sync_bus_w[3:1];
    assign cmd_amount_w = sync_bus_w[5:4];

    // Dispense length for a valid amount code
    function automatic logic [CNT_W-1:0] amount_ticks(input logic [1:0] amt);
        logic [CNT_W-1:0] t;
        case (amt)
            AMT_SMALL: t = c_small_ticks;
            AMT_MED:   t = c_med_ticks;
            AMT_LARGE: t = c_large_ticks;
            default:   t = '0;
        endcase
        return t;
    endfunction

    // Next-state, counter and output decode; outputs describe the state entered
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        motor_d     = motor_q;

        case (state_q)
            ST_IDLE: begin
                if (cf_rise_w) begin
                    if (cmd_amount_w == AMT_INVALID) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d     = ST_LOAD;
                        remaining_d = amount_ticks(cmd_amount_w);
                        drain_d     = c_drain_ticks;
                    end
                end
            end
            ST_LOAD: begin
                if (!cf_w) begin
                    state_d = ST_IDLE;
                end else if (remaining_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort is checked before the tick so it wins a collision
                if (!cf_w) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (remaining_q <= c_one) begin
                        remaining_d = '0;
                        state_d     = ST_DRAIN;
                    end else begin
                        remaining_d = remaining_q - c_one;
                    end
                end
            end
            ST_DRAIN: begin
                if (!cf_w) begin
                    state_d = ST_IDLE;
                end else if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    drain_d = drain_q - c_one;
                    if (drain_q == c_one) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!cf_w) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE: begin
                // Jog only while already idle, so any exit into IDLE
                // spends one cycle with the motors stopped
                if ((state_q == ST_IDLE) && !cf_w) begin
                    motor_d = jog_decode(cmd_state_w);
                end else begin
                    motor_d = MOTORS_OFF;
                end
            end
            ST_RUN: begin
                motor_d = MOTORS_RUN;
            end
            ST_DRAIN: begin
                // DC keeps whatever it was doing; only the stepper stops
                motor_d.stepper_en  = 1'b0;
                motor_d.stepper_dir = 1'b0;
            end
            default: begin
                motor_d = MOTORS_OFF;
            end
        endcase

        handshake_d = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERROR);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN) ||
                      (state_d == ST_DRAIN);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            drain_q     <= '0;
            motor_q     <= MOTORS_OFF;
            handshake_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            motor_q     <= motor_d;
            handshake_q <= handshake_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign stepper_en  = motor_q.stepper_en;
    assign stepper_dir = motor_q.stepper_dir;
    assign dc_dir      = motor_q.dc_dir;
    assign dc_speed    = motor_q.dc_speed;
    assign handshake   = handshake_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign remaining   = remaining_q;

endmodule
`default_nettype wire

// File: tb/tb_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispense_sequencer
// Description : Self-checking bench for dispense_sequencer: jog-mode vector
//               table plus directed dispense, abort, error and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispense_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [2:0] cmd_state;
    logic [1:0] cmd_amount;
    logic       candyflag;
    logic       stepper_en;
    logic       stepper_dir;
    logic [1:0] dc_dir;
    logic [1:0] dc_speed;
    logic       handshake;
    logic       busy;
    logic       err;
    logic [7:0] remaining;

    logic [16:0] act_vec;
    int          n_checks = 0;
    int          n_err    = 0;

    typedef struct packed {
        logic        rst;
        logic [2:0]  st;
        logic [1:0]  amt;
        logic        cf;
        logic [7:0]  cycles;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs [9];

    dispense_sequencer #(
        .CNT_W       (8),
        .SMALL_TICKS (20),
        .MED_TICKS   (35),
        .LARGE_TICKS (45),
        .DRAIN_TICKS (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .cmd_state   (cmd_state),
        .cmd_amount  (cmd_amount),
        .candyflag   (candyflag),
        .stepper_en  (stepper_en),
        .stepper_dir (stepper_dir),
        .dc_dir      (dc_dir),
        .dc_speed    (dc_speed),
        .handshake   (handshake),
        .busy        (busy),
        .err         (err),
        .remaining   (remaining)
    );

    always #5 clk = ~clk;

    assign act_vec = {stepper_en, stepper_dir, dc_dir, dc_speed,
                      handshake, busy, err, remaining};

    // Pack expected outputs in the same order as act_vec
    function automatic logic [16:0] mk(input logic en, input logic dir,
                                       input logic [1:0] dd, input logic [1:0] sp,
                                       input logic hs, input logic bs,
                                       input logic er, input logic [7:0] rem);
        return {en, dir, dd, sp, hs, bs, er, rem};
    endfunction

    function automatic vec_t mkv(input logic r, input logic [2:0] st,
                                 input logic [1:0] amt, input logic cf,
                                 input logic [7:0] cyc_n, input logic [16:0] e);
        vec_t v;
        v.rst = r; v.st = st; v.amt = amt; v.cf = cf;
        v.cycles = cyc_n; v.exp = e;
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [16:0] exp);
        check(name, {15'd0, act_vec}, {15'd0, exp});
    endtask

    // One-cycle tick followed by one quiet cycle
    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst        = 1'b1;
        tick       = 1'b0;
        cmd_state  = 3'b000;
        cmd_amount = 2'b00;
        candyflag  = 1'b0;

        // Reset, then jog-mode decode (3 cycles pin-to-output)
        vecs[0] = mkv(1'b1, 3'b000, 2'b00, 1'b0, 8'd3, mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));
        vecs[1] = mkv(1'b0, 3'b010, 2'b00, 1'b0, 8'd3, mk(1, 1, 2'b10, 2'b00, 0, 0, 0, 8'd0));
        vecs[2] = mkv(1'b0, 3'b110, 2'b00, 1'b0, 8'd3, mk(0, 0, 2'b10, 2'b11, 0, 0, 0, 8'd0));
        vecs[3] = mkv(1'b0, 3'b001, 2'b00, 1'b0, 8'd3, mk(1, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));
        vecs[4] = mkv(1'b0, 3'b011, 2'b00, 1'b0, 8'd3, mk(1, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));
        vecs[5] = mkv(1'b0, 3'b100, 2'b00, 1'b0, 8'd3, mk(0, 0, 2'b10, 2'b01, 0, 0, 0, 8'd0));
        vecs[6] = mkv(1'b0, 3'b101, 2'b00, 1'b0, 8'd3, mk(0, 0, 2'b01, 2'b01, 0, 0, 0, 8'd0));
        vecs[7] = mkv(1'b0, 3'b111, 2'b00, 1'b0, 8'd3, mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));
        vecs[8] = mkv(1'b0, 3'b000, 2'b00, 1'b0, 8'd3, mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));

        for (int i = 0; i < 9; i++) begin
            rst        = vecs[i].rst;
            cmd_state  = vecs[i].st;
            cmd_amount = vecs[i].amt;
            candyflag  = vecs[i].cf;
            cyc(int'(vecs[i].cycles));
            check_all($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Small dispense: LOAD, RUN 20 ticks, DRAIN 4 ticks, DONE
        cmd_amount = 2'b00;
        candyflag  = 1'b1;
        cyc(3);
        check_all("small_load", mk(0, 0, 2'b10, 2'b00, 0, 1, 0, 8'd20));
        cyc(1);
        check_all("small_run", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd20));
        for (int i = 0; i < 19; i++) pulse_tick();
        check_all("small_run_19", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd1));
        pulse_tick();
        check_all("small_drain", mk(0, 0, 2'b01, 2'b10, 0, 1, 0, 8'd0));
        for (int i = 0; i < 3; i++) pulse_tick();
        check_all("small_drain_3", mk(0, 0, 2'b01, 2'b10, 0, 1, 0, 8'd0));
        pulse_tick();
        check_all("small_done", mk(0, 0, 2'b10, 2'b00, 1, 0, 0, 8'd0));
        pulse_tick();
        check_all("done_ignores_tick", mk(0, 0, 2'b10, 2'b00, 1, 0, 0, 8'd0));
        candyflag = 1'b0;
        cyc(2);
        check("hs_hold", {31'd0, handshake}, 32'd1);
        cyc(1);
        check_all("hs_clear", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));

        // Abort of a large dispense after 10 ticks
        cmd_amount = 2'b10;
        candyflag  = 1'b1;
        cyc(4);
        check_all("large_run", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd45));
        for (int i = 0; i < 10; i++) pulse_tick();
        check_all("large_10", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd35));
        candyflag = 1'b0;
        cyc(2);
        check_all("abort_sync_delay", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd35));
        cyc(1);
        check_all("abort", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd35));
        pulse_tick();
        cyc(5);
        check_all("abort_hold", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd35));

        // Invalid amount
        cmd_amount = 2'b11;
        candyflag  = 1'b1;
        cyc(3);
        check_all("invalid_err", mk(0, 0, 2'b10, 2'b00, 0, 0, 1, 8'd35));
        pulse_tick();
        check_all("invalid_tick", mk(0, 0, 2'b10, 2'b00, 0, 0, 1, 8'd35));
        candyflag = 1'b0;
        cyc(3);
        check_all("invalid_clear", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd35));

        // Tick coincident with synchronized candyflag fall in RUN
        cmd_amount = 2'b00;
        candyflag  = 1'b1;
        cyc(4);
        check_all("coinc_run", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd20));
        pulse_tick();
        pulse_tick();
        check_all("coinc_18", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd18));
        candyflag = 1'b0;
        cyc(2);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check_all("abort_beats_tick", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd18));
        cyc(6);
        check_all("abort_no_drain", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd18));

        // Reset pulsed mid-RUN, then candyflag held high across reset exit
        cmd_amount = 2'b01;
        candyflag  = 1'b1;
        cyc(4);
        check_all("med_run", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd35));
        for (int i = 0; i < 3; i++) pulse_tick();
        check_all("med_32", mk(1, 0, 2'b01, 2'b10, 0, 1, 0, 8'd32));
        rst = 1'b1;
        cyc(1);
        check_all("rst_midrun", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));
        cyc(2);
        rst = 1'b0;
        cyc(10);
        check_all("cf_high_reset_exit", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));
        pulse_tick();
        check_all("cf_high_tick", mk(0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0));
        candyflag = 1'b0;
        cyc(4);
        cmd_amount = 2'b00;
        candyflag  = 1'b1;
        cyc(3);
        check_all("rise_after_reset", mk(0, 0, 2'b10, 2'b00, 0, 1, 0, 8'd20));
        candyflag = 1'b0;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
